instr_fetch_unit: RTL and testbench

- Owns the program counter and fetches instructions from instruction memory over a req/rvalid handshake.
- Presents each instruction to decode with a valid/ready handshake.
- Consumes the PC+4 value the sequential-address adder produces; applies jump/branch redirects; discards stale memory responses after a redirect.
- Sits between the PC-increment adder, instruction memory and the decode stage of the processor.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/pc_next_sel.sv | 34 +++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

    // Fetch FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

    localparam int unsigned PC_STEP_DEFAULT  = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instructions are word aligned: drop the two byte-offset bits of a target.
    // Taken 64 bits wide so any WIDTH up to 64 can share it.
    function automatic logic [63:0] align_word(input logic [63:0] target);
        return {target[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump > taken branch > sequential advance > hold, plus the +STEP adder.
// Latency: purely combinational.
// Backpressure: none; advance_i is only raised when decode accepts the held instruction.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = PC_STEP_DEFAULT
) (
    input  logic [WIDTH-1:0] pc_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] next_pc_o,
    output logic [WIDTH-1:0] pc_plus4_o
);

    // Wraps modulo 2^WIDTH by construction of the sum width.
    assign pc_plus4_o = pc_i + WIDTH'(STEP);

    always_comb begin
        next_pc_o = pc_i;
        if (jump_i) begin
            next_pc_o = WIDTH'(align_word(64'(jump_target_i)));
        end else if (branch_taken_i) begin
            next_pc_o = WIDTH'(align_word(64'(branch_target_i)));
        end else if (advance_i) begin
            next_pc_o = pc_plus4_o;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem read at a time, hands the word to decode.
// Latency: 3 cycles minimum req-to-req (REQ, WAIT with rvalid, HOLD with ready); instr_valid 2 cycles after req.
// Backpressure: decode_ready low in HOLD freezes all outputs; redirects discard in-flight responses via DRAIN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned      PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4_out,
    input  logic             decode_ready
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_plus4;
    logic             redirect;
    logic             advance;

    assign redirect = jump | branch_taken;
    // The PC only steps when decode takes the held word and no redirect overrides it.
    assign advance  = (state_q == HOLD) && decode_ready;

    // Redirects update the PC in every state, so pc_d is taken unconditionally.
    pc_next_sel #(
        .WIDTH (WIDTH),
        .STEP  (PC_STEP)
    ) u_pc_next_sel (
        .pc_i            (pc_q),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .advance_i       (advance),
        .next_pc_o       (pc_d),
        .pc_plus4_o      (pc_plus4)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: state_d = REQ;
            // Request already left this cycle; a redirect must drain its response.
            REQ:  state_d = redirect ? DRAIN : WAIT;
            WAIT: begin
                if (redirect) begin
                    // A response landing with the redirect is stale and is dropped.
                    state_d = imem_rvalid ? REQ : DRAIN;
                end else if (imem_rvalid) begin
                    state_d = HOLD;
                    instr_d = imem_rdata;
                end
            end
            HOLD: begin
                if (redirect || decode_ready) begin
                    state_d = REQ;
                end
            end
            // The stale response retires the only outstanding request; a redirect
            // arriving with it has already moved pc, so refetch straight away.
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req     = (state_q == REQ);
    assign imem_addr    = pc_q;
    assign instr_valid  = (state_q == HOLD);
    assign instr_out    = instr_q;
    assign pc_out       = pc_q;
    assign pc_plus4_out = pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle table, corner sequences, randomized run vs. reference model.
// Latency: n/a (bench).
// Backpressure: bench plays memory (1..3 cycle latency) and decode (random ready).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        decode_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .pc_plus4_out  (pc_plus4_out),
        .decode_ready  (decode_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    typedef struct {
        logic        rst_n;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rd, input logic rdy,
                                input logic q, input logic [31:0] a, input logic v,
                                input logic [31:0] ins, input logic [31:0] p, input logic [31:0] p4);
        vec_t t;
        t.rst_n = r;  t.rvalid = rv; t.rdata = rd; t.ready = rdy;
        t.req = q;    t.addr = a;    t.valid = v;  t.instr = ins; t.pc = p; t.pc4 = p4;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; one-cycle pulses end here.
    task automatic tick();
        @(posedge clk);
        #1;
        jump = 1'b0;
        branch_taken = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        decode_ready = 1'b0;
        jump = 1'b0;
        branch_taken = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (imem_req) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    vec_t        vecs[15];
    logic [31:0] exp_pc, exp_instr, outst_addr, tgt;
    bit          have_instr, was_have, outst, good, rv, redir, accept;
    int          resp_in, accepted;

    initial begin
        // Reset, first fetch, stall in HOLD for 3 cycles, sequential 0/4/8/12.
        vecs[0]  = mk(0, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0,         32'h0, 32'h4);
        vecs[1]  = mk(1, 0, 32'h0,         0, 0, 32'h0, 0, 32'h0,         32'h0, 32'h4);
        vecs[2]  = mk(1, 0, 32'h0,         0, 1, 32'h0, 0, 32'h0,         32'h0, 32'h4);
        vecs[3]  = mk(1, 1, 32'h2001_0005, 0, 0, 32'h0, 0, 32'h0,         32'h0, 32'h4);
        vecs[4]  = mk(1, 0, 32'h0,         1, 0, 32'h0, 1, 32'h2001_0005, 32'h0, 32'h4);
        vecs[5]  = mk(1, 0, 32'h0,         0, 1, 32'h4, 0, 32'h2001_0005, 32'h4, 32'h8);
        vecs[6]  = mk(1, 1, 32'hCAFE_0004, 0, 0, 32'h4, 0, 32'h2001_0005, 32'h4, 32'h8);
        vecs[7]  = mk(1, 0, 32'h0,         0, 0, 32'h4, 1, 32'hCAFE_0004, 32'h4, 32'h8);
        vecs[8]  = mk(1, 0, 32'h0,         0, 0, 32'h4, 1, 32'hCAFE_0004, 32'h4, 32'h8);
        vecs[9]  = mk(1, 0, 32'h0,         0, 0, 32'h4, 1, 32'hCAFE_0004, 32'h4, 32'h8);
        vecs[10] = mk(1, 0, 32'h0,         1, 0, 32'h4, 1, 32'hCAFE_0004, 32'h4, 32'h8);
        vecs[11] = mk(1, 0, 32'h0,         0, 1, 32'h8, 0, 32'hCAFE_0004, 32'h8, 32'hC);
        vecs[12] = mk(1, 1, 32'h0BAD_F00D, 0, 0, 32'h8, 0, 32'hCAFE_0004, 32'h8, 32'hC);
        vecs[13] = mk(1, 0, 32'h0,         1, 0, 32'h8, 1, 32'h0BAD_F00D, 32'h8, 32'hC);
        vecs[14] = mk(1, 0, 32'h0,         0, 1, 32'hC, 0, 32'h0BAD_F00D, 32'hC, 32'h10);

        for (int i = 0; i < 15; i++) begin
            tick();
            rst_n        = vecs[i].rst_n;
            imem_rvalid  = vecs[i].rvalid;
            imem_rdata   = vecs[i].rdata;
            decode_ready = vecs[i].ready;
            #1;
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
            if (vecs[i].req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_instr", i), instr_out, vecs[i].instr);
            chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].pc);
            chk($sformatf("vec%0d_pc4", i), pc_plus4_out, vecs[i].pc4);
        end

        // Wrap: jump in IDLE to an unaligned top-of-space target.
        do_reset();
        jump = 1'b1;
        jump_target = 32'hFFFF_FFFF;
        tick();
        chk("wrap_req", 32'(imem_req), 32'd1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4_out, 32'h0000_0000);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        tick();
        chk("wrap_valid", 32'(instr_valid), 32'd1);
        chk("wrap_instr", instr_out, 32'h0000_0013);
        chk("wrap_hold_pc", pc_out, 32'hFFFF_FFFC);
        decode_ready = 1'b1;
        tick();
        chk("wrap_next_req", 32'(imem_req), 32'd1);
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);

        // Redirect during WAIT, memory answers 3 cycles after the request.
        do_reset();
        wait_req("wwait_first_req");
        tick();
        jump = 1'b1;
        jump_target = 32'h0000_0042;
        tick();
        chk("wwait_drain_valid", 32'(instr_valid), 32'd0);
        chk("wwait_drain_pc", pc_out, 32'h0000_0040);
        chk("wwait_drain_req", 32'(imem_req), 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        chk("wwait_req", 32'(imem_req), 32'd1);
        chk("wwait_addr", imem_addr, 32'h0000_0040);
        chk("wwait_valid", 32'(instr_valid), 32'd0);
        chk("wwait_instr_kept", instr_out, 32'h0000_0000);

        // Jump and branch together in HOLD with decode ready.
        do_reset();
        decode_ready = 1'b1;
        wait_req("both_first_req");
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0001;
        tick();
        chk("both_hold_valid", 32'(instr_valid), 32'd1);
        jump = 1'b1;
        jump_target = 32'h0000_0100;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0200;
        tick();
        chk("both_req", 32'(imem_req), 32'd1);
        chk("both_addr", imem_addr, 32'h0000_0100);
        chk("both_valid_drop", 32'(instr_valid), 32'd0);

        // Reset while in WAIT, late response right after release.
        do_reset();
        decode_ready = 1'b1;
        wait_req("rst_first_req");
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0077;
        tick();
        tick();
        chk("rst_second_addr", imem_addr, 32'h0000_0004);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_async_req", 32'(imem_req), 32'd0);
        chk("rst_async_valid", 32'(instr_valid), 32'd0);
        chk("rst_async_pc", pc_out, 32'h0);
        chk("rst_async_pc4", pc_plus4_out, 32'h4);
        chk("rst_async_instr", instr_out, 32'h0);
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        chk("rst_fresh_req", 32'(imem_req), 32'd1);
        chk("rst_fresh_addr", imem_addr, 32'h0);
        chk("rst_fresh_instr", instr_out, 32'h0);
        tick();
        tick();
        chk("rst_late_ignored", 32'(instr_valid), 32'd0);

        // Randomized run against a transaction-level model: expected fetch PC,
        // single outstanding request, stale marking on redirect, delivered word.
        do_reset();
        exp_pc = 32'h0; have_instr = 0; outst = 0; good = 0; resp_in = 0; accepted = 0;
        outst_addr = 32'h0; exp_instr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (imem_req) begin
                chk("rnd_req_addr", imem_addr, exp_pc);
                chk("rnd_one_outstanding", 32'(outst), 32'd0);
            end
            chk("rnd_valid", 32'(instr_valid), 32'(have_instr));
            if (instr_valid && have_instr) begin
                chk("rnd_instr", instr_out, exp_instr);
                chk("rnd_pc", pc_out, exp_pc);
                chk("rnd_pc4", pc_plus4_out, exp_pc + 32'd4);
            end

            rv = 0;
            if (outst) begin
                resp_in--;
                if (resp_in == 0) rv = 1;
            end
            jump          = ($urandom_range(0, 15) == 0);
            jump_target   = $urandom;
            branch_taken  = ($urandom_range(0, 11) == 0);
            branch_target = $urandom;
            decode_ready  = ($urandom_range(0, 3) != 0);
            imem_rvalid   = rv;
            imem_rdata    = rv ? mem_word(outst_addr) : $urandom;

            was_have = have_instr;
            redir    = jump | branch_taken;
            tgt      = jump ? (jump_target & 32'hFFFF_FFFC) : (branch_target & 32'hFFFF_FFFC);
            accept   = was_have && decode_ready && !redir;
            if (rv) begin
                outst = 0;
                if (good && !redir) begin
                    have_instr = 1;
                    exp_instr  = mem_word(outst_addr);
                end
            end
            if (imem_req) begin
                outst      = 1;
                good       = 1;
                outst_addr = imem_addr;
                resp_in    = $urandom_range(1, 3);
            end
            if (redir) begin
                exp_pc     = tgt;
                have_instr = 0;
                good       = 0;
            end else if (accept) begin
                exp_pc     = exp_pc + 32'd4;
                have_instr = 0;
                accepted++;
            end
        end
        chk("rnd_progress", 32'(accepted >= 50), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
